// File: rtl/sprite_bus_pkg.sv
// Shared definitions for the sprite command bus: field positions, info codes,
// the command word layout and a small decode helper used by the queue and
// by every sprite display unit.
package sprite_bus_pkg;

    // Bit positions of each field inside a 32-bit command word.
    localparam int SUB_COMP_MSB   = 31;
    localparam int SUB_COMP_LSB   = 26;
    localparam int CHILD_COMP_MSB = 25;
    localparam int CHILD_COMP_LSB = 21;
    localparam int INFO_MSB       = 20;
    localparam int INFO_LSB       = 17;
    localparam int INPUT_TYPE_MSB = 16;
    localparam int INPUT_TYPE_LSB = 14;
    localparam int PP_SELC_BIT    = 13;
    localparam int MSG_MSB        = 12;
    localparam int MSG_LSB        = 0;

    // Info codes. Info 0 is the idle no-op the bus carries between commands.
    localparam logic [3:0] INFO_NOP   = 4'h0;
    localparam logic [3:0] INFO_WRITE = 4'h1;
    localparam logic [3:0] INFO_FLUSH = 4'hF;

    // First vcount value of vertical blank for 640x480 timing.
    localparam int V_ACTIVE_DEFAULT = 480;

    // Command word layout, MSB first.
    typedef struct packed {
        logic [5:0]  sub_comp;
        logic [4:0]  child_comp;
        logic [3:0]  info;
        logic [2:0]  input_type;
        logic        pp_selc;
        logic [12:0] msg;
    } sprite_cmd_t;

    // True when a raw command word carries the flush info code.
    function automatic logic is_flush(input logic [31:0] word);
        return word[INFO_MSB:INFO_LSB] == INFO_FLUSH;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command storage: DEPTH x 32 synchronous FIFO with a combinational head
// read. A push while full is only taken when a pop frees a slot in the
// same cycle; a pop while empty is ignored.
module cmd_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [31:0]                i_wr_data,
    output logic [31:0]                o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/sprite_cmd_queue.sv
// Sprite command queue: the CPU writes command words over Avalon-MM, they
// are buffered in cmd_fifo and issued one per cycle onto cmd_data. A flush
// word at the head holds itself and everything behind it until vertical
// blank, so display units swap buffers only outside the active picture.
//
// Bus handshake: there is no waitrequest. A write (chipselect & write) is
// taken in the cycle it is presented; a command write that finds the FIFO
// full with no pop that cycle is dropped and flagged in overflow. A read
// (chipselect & read) captures the status word at the clock edge, and
// readdata holds it from the following cycle until the next read.
module sprite_cmd_queue
    import sprite_bus_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic        address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_data
);

    localparam int         CW          = $clog2(DEPTH) + 1;
    localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);

    // FIFO interface
    logic [31:0]   w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    // Issue and bus decode
    logic w_cmd_wr;
    logic w_clr_wr;
    logic w_head_flush;
    logic w_stall;
    logic w_pop;
    logic w_push_ok;
    logic w_in_blank;

    // Status assembly
    logic [7:0]  w_count8;
    logic [15:0] w_status_hi;
    logic [31:0] w_status;

    // hcount is reserved for a future hblank gating mode.
    logic w_unused_hcount;

    // Registers
    logic [31:0] r_stage;
    logic [31:0] r_cmd_data;
    logic [31:0] r_readdata;
    logic        r_overflow;
    logic [15:0] r_flushes;

    assign w_unused_hcount = ^hcount;

    assign w_cmd_wr   = chipselect && write && !address;
    assign w_clr_wr   = chipselect && write && address;
    assign w_in_blank = (vcount >= LP_V_ACTIVE);

    // A flush at the head blocks the whole queue during active video.
    assign w_head_flush = !w_empty && is_flush(w_head);
    assign w_stall      = w_head_flush && !w_in_blank;
    assign w_pop        = !w_empty && !w_stall;
    assign w_push_ok    = w_cmd_wr && (!w_full || w_pop);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .i_push    (w_push_ok),
        .i_pop     (w_pop),
        .i_wr_data (writedata),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // Issue stage: capture the popped word, or the no-op word when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_pop ? w_head : 32'h0;
        end
    end

    // Output register: each popped word drives the bus for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_data <= '0;
        end else begin
            r_cmd_data <= r_stage;
        end
    end

    // Count flushes as they go out on the bus; wraps at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flushes <= '0;
        end else if (is_flush(r_stage)) begin
            r_flushes <= r_flushes + 16'd1;
        end
    end

    // Sticky overflow: set by a dropped push, cleared by a status write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_cmd_wr && !w_push_ok) begin
            r_overflow <= 1'b1;
        end else if (w_clr_wr && writedata[0]) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_count8    = 8'(w_count);
    assign w_status_hi = address ? r_flushes : 16'h0;
    assign w_status    = {w_status_hi, 4'h0, w_stall, r_overflow,
                          w_empty, w_full, w_count8};

    // Status read port, captured on every read strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
        end else if (chipselect && read) begin
            r_readdata <= w_status;
        end
    end

    assign cmd_data = r_cmd_data;
    assign readdata = r_readdata;

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Directed bench for sprite_cmd_queue: latency, flush stalling in active
// video, overflow, full-with-pop, reset during a stall and pointer wrap.
module tb_sprite_cmd_queue;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic        address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] cmd_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];

    localparam logic [31:0] WORD_A = 32'h04022001;
    localparam logic [31:0] WORD_F = 32'h001E2000;
    localparam logic [31:0] WORD_B = 32'h0402A5A5;
    localparam logic [31:0] WORD_W = 32'h04020100;

    sprite_cmd_queue #(
        .DEPTH    (16),
        .V_ACTIVE (480)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .hcount     (hcount),
        .vcount     (vcount),
        .cmd_data   (cmd_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // driver tasks: called at a falling edge, return at the next one
    task automatic bus_write(input logic a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        address    = 1'b0;
    endtask

    task automatic bus_read(input logic a);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        read       = 1'b0;
        address    = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // directed sequence with scoreboard
    initial begin
        int nz;
        logic [31:0] w;

        reset      = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 1'b0;
        writedata  = '0;
        hcount     = '0;
        vcount     = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_data", cmd_data, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        bus_read(1'b0);
        check("idle_status", readdata, 32'h00000200);

        // single write: two edges of latency, one cycle wide
        vcount = 10'd100;
        bus_write(1'b0, WORD_A);
        check("lat_edge_n", cmd_data, 32'h0);
        @(negedge clk);
        check("lat_edge_n1", cmd_data, 32'h0);
        @(negedge clk);
        check("lat_edge_n2", cmd_data, WORD_A);
        @(negedge clk);
        check("lat_edge_n3", cmd_data, 32'h0);

        // write, flush, write in active video
        vcount = 10'd200;
        bus_write(1'b0, WORD_A);
        bus_write(1'b0, WORD_F);
        bus_write(1'b0, WORD_B);
        check("flush_a_out", cmd_data, WORD_A);
        @(negedge clk);
        check("flush_stall0", cmd_data, 32'h0);
        bus_read(1'b0);
        check("flush_pending", readdata, 32'h00000802);
        check("flush_stall1", cmd_data, 32'h0);
        vcount = 10'd480;
        @(negedge clk);
        check("flush_rel0", cmd_data, 32'h0);
        @(negedge clk);
        check("flush_out", cmd_data, WORD_F);
        @(negedge clk);
        check("flush_b_out", cmd_data, WORD_B);
        @(negedge clk);
        check("flush_after", cmd_data, 32'h0);
        bus_read(1'b1);
        check("flush_count1", readdata, 32'h00010200);

        // overflow while a flush holds the queue
        vcount = 10'd0;
        bus_write(1'b0, WORD_F);
        for (int i = 1; i <= 16; i++) begin
            bus_write(1'b0, 32'h04020000 + 32'(i));
        end
        bus_read(1'b0);
        check("ovf_status", readdata, 32'h00000D10);
        bus_write(1'b1, 32'h00000001);
        bus_read(1'b0);
        check("ovf_cleared", readdata, 32'h00000910);

        // full queue starts draining; a push in the pop cycle is kept
        vcount = 10'd480;
        bus_write(1'b0, WORD_W);
        bus_read(1'b0);
        check("full_push_pop", readdata, 32'h00000110);
        check("drain_flush", cmd_data, WORD_F);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("drain_word", cmd_data, 32'h04020000 + 32'(k));
        end
        @(negedge clk);
        check("drain_last", cmd_data, WORD_W);
        @(negedge clk);
        check("drain_idle", cmd_data, 32'h0);

        // reset while words wait behind a stalled flush
        vcount = 10'd0;
        bus_write(1'b0, WORD_F);
        for (int i = 0; i < 5; i++) begin
            bus_write(1'b0, 32'h04021000 + 32'(i));
        end
        bus_read(1'b1);
        check("pre_reset", readdata, 32'h00020806);
        reset = 1'b0;
        #1;
        check("async_cmd", cmd_data, 32'h0);
        check("async_rd", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nz = 0;
        for (int v = 0; v < 525; v++) begin
            vcount = 10'(v);
            hcount = 10'($urandom_range(0, 799));
            @(negedge clk);
            if (cmd_data !== 32'h0) nz++;
        end
        check("frame_quiet", 32'(nz), 32'h0);
        bus_read(1'b1);
        check("post_reset", readdata, 32'h00000200);

        // 40 back-to-back words through the queue; pointers wrap
        vcount = 10'd100;
        for (int i = 0; i < 44; i++) begin
            if (i < 40) begin
                w = {6'(i), 5'd2, 4'h1, 3'(i), i[0], 13'(i * 97 + 3)};
                chipselect = 1'b1;
                write      = 1'b1;
                address    = 1'b0;
                writedata  = w;
                exp_q.push_back(w);
            end else begin
                chipselect = 1'b0;
                write      = 1'b0;
            end
            hcount = 10'($urandom_range(0, 799));
            @(negedge clk);
            if (i >= 2 && i < 42) begin
                check("wrap_order", cmd_data, exp_q.pop_front());
            end else begin
                check("wrap_idle", cmd_data, 32'h0);
            end
        end
        check("wrap_q_empty", 32'(exp_q.size()), 32'h0);
        bus_read(1'b0);
        check("wrap_status", readdata, 32'h00000200);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
